// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks: FSM encoding, parity modes,
// and the divisor clamp that turns a zero divisor into one-cycle bits.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  function automatic logic [31:0] eff_div(input logic [31:0] div);
    return (div == 32'd0) ? 32'd1 : div;
  endfunction

  // Mode 2'b11 behaves like PAR_NONE.
  function automatic logic parity_on(input logic [1:0] mode);
    return (mode == PAR_EVEN) || (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with push/pop and an occupancy count; full and empty are
// derived from the count so the pointers can wrap freely.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      level_q;
  logic             wr_en, rd_en;

  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign empty_o = (level_q == '0);
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;
  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a small FIFO; frames are launched back-to-back with
// configuration and divisor captured at the start of each frame.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int DIV_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic [DIV_WIDTH-1:0]          cfg_baud_div,
  input  logic [1:0]                    cfg_parity,
  input  logic                          cfg_two_stop,
  input  logic                          tx_en,
  input  logic                          in_valid,
  input  logic [DATA_BITS-1:0]          in_data,
  output logic                          in_ready,
  output logic                          tx,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int BW = $clog2(DATA_BITS);

  uart_state_e            state_q;
  logic [DIV_WIDTH-1:0]   cnt_q, div_q, div_eff;
  logic [DATA_BITS-1:0]   shift_q, head;
  logic [BW-1:0]          bit_q;
  logic                   par_en_q, par_bit_q, two_stop_q, tx_q, tx_done_q;
  logic                   fifo_full, fifo_empty, bit_end, stop_end, launch;

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .push_i  (in_valid && in_ready),
    .pop_i   (launch),
    .wdata_i (in_data),
    .rdata_o (head),
    .level_o (fifo_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign in_ready = !fifo_full;
  assign div_eff  = DIV_WIDTH'(eff_div(32'(cfg_baud_div)));
  assign bit_end  = (cnt_q == '0);
  // bit_q doubles as the stop-bit index: 0 = first stop, 1 = second stop.
  assign stop_end = (state_q == ST_STOP) && bit_end && (!two_stop_q || bit_q[0]);
  assign launch   = tx_en && !fifo_empty && ((state_q == ST_IDLE) || stop_end);

  assign tx      = tx_q;
  assign tx_done = tx_done_q;
  assign busy    = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= '0;
      shift_q    <= '0;
      bit_q      <= '0;
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      tx_done_q  <= 1'b0;
    end else begin
      tx_done_q <= 1'b0;
      if (launch) begin
        state_q    <= ST_START;
        tx_q       <= 1'b0;
        shift_q    <= head;
        div_q      <= div_eff;
        cnt_q      <= div_eff - 1'b1;
        par_en_q   <= parity_on(cfg_parity);
        par_bit_q  <= (^head) ^ (cfg_parity == PAR_ODD);
        two_stop_q <= cfg_two_stop;
        bit_q      <= '0;
        if (state_q == ST_STOP) tx_done_q <= 1'b1;
      end else if (state_q != ST_IDLE) begin
        if (!bit_end) begin
          cnt_q <= cnt_q - 1'b1;
        end else begin
          cnt_q <= div_q - 1'b1;
          case (state_q)
            ST_START: begin
              state_q <= ST_DATA;
              tx_q    <= shift_q[0];
              shift_q <= shift_q >> 1;
              bit_q   <= '0;
            end
            ST_DATA: begin
              if (bit_q == BW'(DATA_BITS - 1)) begin
                bit_q <= '0;
                if (par_en_q) begin
                  state_q <= ST_PARITY;
                  tx_q    <= par_bit_q;
                end else begin
                  state_q <= ST_STOP;
                  tx_q    <= 1'b1;
                end
              end else begin
                bit_q   <= bit_q + 1'b1;
                tx_q    <= shift_q[0];
                shift_q <= shift_q >> 1;
              end
            end
            ST_PARITY: begin
              state_q <= ST_STOP;
              tx_q    <= 1'b1;
              bit_q   <= '0;
            end
            ST_STOP: begin
              if (!stop_end) begin
                bit_q <= bit_q + 1'b1;
              end else begin
                tx_done_q <= 1'b1;
                state_q   <= ST_IDLE;
              end
            end
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: pushed words queue an expected frame,
// which is then checked cycle-by-cycle on the tx line.
module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        resetn;
  logic [15:0] cfg_baud_div;
  logic [1:0]  cfg_parity;
  logic        cfg_two_stop, tx_en;
  logic        in_valid8, in_valid5;
  logic [7:0]  in_data8;
  logic [4:0]  in_data5;
  logic        in_ready8, tx8, busy8, done8;
  logic        in_ready5, tx5, busy5, done5;
  logic [2:0]  level8, level5;

  always #5 clk = ~clk;

  uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u_dut8 (
    .clk(clk), .resetn(resetn), .cfg_baud_div(cfg_baud_div), .cfg_parity(cfg_parity),
    .cfg_two_stop(cfg_two_stop), .tx_en(tx_en), .in_valid(in_valid8), .in_data(in_data8),
    .in_ready(in_ready8), .tx(tx8), .busy(busy8), .tx_done(done8), .fifo_level(level8));

  uart_tx_fifo #(.DATA_BITS(5), .FIFO_DEPTH(4), .DIV_WIDTH(16)) u_dut5 (
    .clk(clk), .resetn(resetn), .cfg_baud_div(cfg_baud_div), .cfg_parity(cfg_parity),
    .cfg_two_stop(cfg_two_stop), .tx_en(tx_en), .in_valid(in_valid5), .in_data(in_data5),
    .in_ready(in_ready5), .tx(tx5), .busy(busy5), .tx_done(done5), .fifo_level(level5));

  typedef struct {
    logic [8:0] data;
    int         div;
    logic [1:0] par;
    bit         two;
    int         nbits;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic tx_of(input bit sel);    return sel ? tx5 : tx8;             endfunction
  function automatic logic done_of(input bit sel);  return sel ? done5 : done8;         endfunction
  function automatic logic busy_of(input bit sel);  return sel ? busy5 : busy8;         endfunction
  function automatic logic ready_of(input bit sel); return sel ? in_ready5 : in_ready8; endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_word(input bit sel, input logic [8:0] data, input int div,
                           input logic [1:0] par, input bit two, input bit accept);
    exp_t e;
    if (sel) begin in_valid5 = 1'b1; in_data5 = data[4:0]; end
    else     begin in_valid8 = 1'b1; in_data8 = data[7:0]; end
    checks++;
    if (ready_of(sel) !== accept) begin
      errors++;
      $display("FAIL push_ready data=%h: in_ready %b required %b", data, ready_of(sel), accept);
    end
    @(posedge clk);
    #1;
    in_valid5 = 1'b0;
    in_valid8 = 1'b0;
    if (accept) begin
      e.data = data; e.div = div; e.par = par; e.two = two; e.nbits = sel ? 5 : 8;
      sb_q.push_back(e);
    end
    @(negedge clk);
  endtask

  // Pops one expected frame and checks every cycle of it; exp_gap < 0 skips the
  // idle-gap check. Returns at the negedge where tx_done must be high.
  task automatic check_frame(input bit sel, input int exp_gap);
    exp_t e;
    int   gap, nb;
    logic bits [16];
    logic p, seen;
    bit   bad, early_done;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $display("FAIL sb_empty: queued frames 0 required >0");
      return;
    end
    e = sb_q.pop_front();
    gap = 0;
    while (tx_of(sel) !== 1'b0 && gap < 5000) begin
      @(negedge clk);
      gap++;
    end
    checks++;
    if (gap >= 5000) begin
      errors++;
      $display("FAIL start_timeout data=%h: no start bit within %0d cycles", e.data, gap);
      return;
    end
    if (exp_gap >= 0) begin
      checks++;
      if (gap != exp_gap) begin
        errors++;
        $display("FAIL start_gap data=%h: gap %0d required %0d", e.data, gap, exp_gap);
      end
    end
    nb = 0;
    bits[nb] = 1'b0; nb = nb + 1;
    p = 1'b0;
    for (int i = 0; i < e.nbits; i++) begin
      bits[nb] = e.data[i]; nb = nb + 1;
      p = p ^ e.data[i];
    end
    if (e.par == 2'b01) begin bits[nb] = p;  nb = nb + 1; end
    if (e.par == 2'b10) begin bits[nb] = ~p; nb = nb + 1; end
    bits[nb] = 1'b1; nb = nb + 1;
    if (e.two) begin bits[nb] = 1'b1; nb = nb + 1; end
    checks++;
    if (busy_of(sel) !== 1'b1) begin
      errors++;
      $display("FAIL busy_in_frame data=%h: busy %b required 1", e.data, busy_of(sel));
    end
    early_done = 1'b0;
    for (int b = 0; b < nb; b++) begin
      bad = 1'b0;
      seen = bits[b];
      for (int c = 0; c < e.div; c++) begin
        if (tx_of(sel) !== bits[b]) begin bad = 1'b1; seen = tx_of(sel); end
        if (!(b == 0 && c == 0) && done_of(sel) !== 1'b0) early_done = 1'b1;
        @(negedge clk);
      end
      checks++;
      if (bad) begin
        errors++;
        $display("FAIL frame_bit data=%h bit %0d: tx %b required %b", e.data, b, seen, bits[b]);
      end
    end
    checks++;
    if (early_done) begin
      errors++;
      $display("FAIL early_done data=%h: tx_done 1 inside frame required 0", e.data);
    end
    checks++;
    if (done_of(sel) !== 1'b1) begin
      errors++;
      $display("FAIL tx_done data=%h: tx_done %b required 1", e.data, done_of(sel));
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    cfg_baud_div = 16'd4; cfg_parity = 2'b00; cfg_two_stop = 1'b0; tx_en = 1'b1;
    in_valid8 = 1'b0; in_valid5 = 1'b0; in_data8 = '0; in_data5 = '0;
    repeat (3) @(negedge clk);
    checks++; if (tx8 !== 1'b1)      begin errors++; $display("FAIL reset_tx: %b required 1", tx8); end
    checks++; if (busy8 !== 1'b0)    begin errors++; $display("FAIL reset_busy: %b required 0", busy8); end
    checks++; if (done8 !== 1'b0)    begin errors++; $display("FAIL reset_done: %b required 0", done8); end
    checks++; if (level8 !== 3'd0)   begin errors++; $display("FAIL reset_level: %0d required 0", level8); end
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL reset_ready: %b required 1", in_ready8); end
    checks++; if (tx5 !== 1'b1)      begin errors++; $display("FAIL reset_tx5: %b required 1", tx5); end
    resetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    cfg_baud_div = 16'd4; cfg_parity = 2'b00; cfg_two_stop = 1'b0; tx_en = 1'b1;
    push_word(0, 9'h0A5, 4, 2'b00, 0, 1);
    check_frame(0, 1);
    @(negedge clk);
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL idle_after_frame: busy %b required 0", busy8); end
  endtask

  task automatic test_parity();
    cfg_baud_div = 16'd2; cfg_two_stop = 1'b0;
    cfg_parity = 2'b01; push_word(0, 9'h007, 2, 2'b01, 0, 1); check_frame(0, 1);
    cfg_parity = 2'b10; push_word(0, 9'h007, 2, 2'b10, 0, 1); check_frame(0, -1);
    cfg_parity = 2'b00; cfg_two_stop = 1'b1;
    push_word(0, 9'h05A, 2, 2'b00, 1, 1); check_frame(0, -1);
    cfg_parity = 2'b11; cfg_two_stop = 1'b0;
    push_word(0, 9'h081, 2, 2'b11, 0, 1); check_frame(0, -1);
    cfg_parity = 2'b00;
  endtask

  task automatic test_fifo_full();
    cfg_baud_div = 16'd2; cfg_parity = 2'b00; cfg_two_stop = 1'b0; tx_en = 1'b0;
    push_word(0, 9'h011, 2, 2'b00, 0, 1);
    push_word(0, 9'h022, 2, 2'b00, 0, 1);
    push_word(0, 9'h0C4, 2, 2'b00, 0, 1);
    push_word(0, 9'h0F8, 2, 2'b00, 0, 1);
    push_word(0, 9'h099, 2, 2'b00, 0, 0);
    checks++;
    if (level8 !== 3'd4) begin errors++; $display("FAIL full_level: %0d required 4", level8); end
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL held_by_tx_en: busy %b required 0", busy8); end
    tx_en = 1'b1;
    check_frame(0, 1);
    check_frame(0, 0);
    check_frame(0, 0);
    check_frame(0, 0);
    @(negedge clk);
    checks++;
    if (level8 !== 3'd0) begin errors++; $display("FAIL drained_level: %0d required 0", level8); end
  endtask

  task automatic test_divisor();
    cfg_parity = 2'b00; cfg_two_stop = 1'b0; tx_en = 1'b1;
    cfg_baud_div = 16'd0;
    push_word(0, 9'h03C, 1, 2'b00, 0, 1);
    check_frame(0, 1);
    @(negedge clk);
    cfg_baud_div = 16'd3;
    push_word(0, 9'h096, 3, 2'b00, 0, 1);
    push_word(0, 9'h069, 5, 2'b00, 0, 1);
    fork
      begin
        check_frame(0, 0);
        check_frame(0, 0);
      end
      begin
        repeat (6) @(negedge clk);
        cfg_baud_div = 16'd5;
      end
    join
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    cfg_baud_div = 16'd4; cfg_parity = 2'b00; cfg_two_stop = 1'b0; tx_en = 1'b1;
    push_word(0, 9'h0C3, 4, 2'b00, 0, 1);
    push_word(0, 9'h011, 4, 2'b00, 0, 1);
    repeat (12) @(negedge clk);
    checks++;
    if (busy8 !== 1'b1) begin errors++; $display("FAIL pre_reset_busy: %b required 1", busy8); end
    resetn = 1'b0;
    #1;
    checks++; if (tx8 !== 1'b1)       begin errors++; $display("FAIL midreset_tx: %b required 1", tx8); end
    checks++; if (busy8 !== 1'b0)     begin errors++; $display("FAIL midreset_busy: %b required 0", busy8); end
    checks++; if (level8 !== 3'd0)    begin errors++; $display("FAIL midreset_level: %0d required 0", level8); end
    checks++; if (in_ready8 !== 1'b1) begin errors++; $display("FAIL midreset_ready: %b required 1", in_ready8); end
    sb_q.delete();
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    push_word(0, 9'h03C, 4, 2'b00, 0, 1);
    check_frame(0, 1);
  endtask

  task automatic test_narrow();
    cfg_baud_div = 16'd4; cfg_parity = 2'b00; cfg_two_stop = 1'b0; tx_en = 1'b1;
    @(negedge clk);
    push_word(1, 9'h015, 4, 2'b00, 0, 1);
    check_frame(1, 1);
    checks++;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL wide_untouched: busy %b required 0", busy8); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_fifo_full();
    test_divisor();
    test_reset_mid();
    test_narrow();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
